// File: rtl/mem_arbiter.sv
// Shares one RAM port between the instruction-fetch and data requesters.
// It alternates grants on contention, waits on ram_ready, and parks in a sticky error state if the RAM hangs.
module mem_arbiter #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IACC  = 3'd1,
    S_DACC  = 3'd2,
    S_IDONE = 3'd3,
    S_DDONE = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_e      state_q, state_d;
  logic        last_d_q, last_d_d;
  logic        wr_q, wr_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] ramaddr_q, ramaddr_d;
  logic [31:0] ramstore_q, ramstore_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;
  logic        ihit_q, ihit_d;
  logic        dhit_q, dhit_d;
  logic        ramren_q, ramren_d;
  logic        ramwen_q, ramwen_d;
  logic        busy_q, busy_d;
  logic        timeout_q, timeout_d;
  logic        d_req_s;

  assign d_req_s = dREN | dWEN;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; on a tie last_d_q picks the requester not served last time
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (d_req_s && (!iREN || !last_d_q)) begin
          state_d = S_DACC;
        end else if (iREN) begin
          state_d = S_IACC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IACC: begin
        if (ram_ready) begin
          state_d = S_IDONE;
        end else if (wait_cnt_q == MAX_WAIT_C) begin
          state_d = S_ERR;
        end else begin
          state_d = S_IACC;
        end
      end
      S_DACC: begin
        if (ram_ready) begin
          state_d = S_DDONE;
        end else if (wait_cnt_q == MAX_WAIT_C) begin
          state_d = S_ERR;
        end else begin
          state_d = S_DACC;
        end
      end
      S_IDONE: state_d = S_IDLE;
      S_DDONE: state_d = S_IDLE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant capture, wait counting, load-data latching and fairness flag
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    last_d_d   = last_d_q;
    wr_d       = wr_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    iload_d    = iload_q;
    dload_d    = dload_q;
    case (state_q)
      S_IDLE: begin
        wait_cnt_d = 8'd0;
        if (state_d == S_DACC) begin
          ramaddr_d  = daddr;
          ramstore_d = dstore;
          wr_d       = dWEN;
        end else if (state_d == S_IACC) begin
          ramaddr_d = iaddr;
        end else begin
          ramaddr_d = ramaddr_q;
        end
      end
      S_IACC, S_DACC: begin
        if (ram_ready) begin
          if (state_q == S_IACC) begin
            iload_d = ramload;
          end else if (!wr_q) begin
            dload_d = ramload;
          end else begin
            dload_d = dload_q;
          end
        end else if (wait_cnt_q != MAX_WAIT_C) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          wait_cnt_d = wait_cnt_q;
        end
      end
      S_IDONE: last_d_d = 1'b0;
      S_DDONE: last_d_d = 1'b1;
      S_ERR:   wait_cnt_d = wait_cnt_q;
      default: wait_cnt_d = wait_cnt_q;
    endcase
  end

  // Output decode from the next state so every port comes straight off a flop
  always_comb begin
    ramren_d  = (state_d == S_IACC) || ((state_d == S_DACC) && !wr_d);
    ramwen_d  = (state_d == S_DACC) && wr_d;
    ihit_d    = (state_d == S_IDONE);
    dhit_d    = (state_d == S_DDONE);
    busy_d    = (state_d != S_IDLE);
    timeout_d = (state_d == S_ERR);
  end

  // Datapath and output registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_d_q   <= 1'b0;
      wr_q       <= 1'b0;
      wait_cnt_q <= 8'd0;
      ramaddr_q  <= 32'd0;
      ramstore_q <= 32'd0;
      iload_q    <= 32'd0;
      dload_q    <= 32'd0;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      ramren_q   <= 1'b0;
      ramwen_q   <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      last_d_q   <= last_d_d;
      wr_q       <= wr_d;
      wait_cnt_q <= wait_cnt_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      iload_q    <= iload_d;
      dload_q    <= dload_d;
      ihit_q     <= ihit_d;
      dhit_q     <= dhit_d;
      ramren_q   <= ramren_d;
      ramwen_q   <= ramwen_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign iload    = iload_q;
  assign dload    = dload_q;
  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign ramREN   = ramren_q;
  assign ramWEN   = ramwen_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule
